// File: rtl/encoder_out_fifo_pkg.sv
// Shared definitions for the encoder output FIFO: pointer sizing, entry layout, reset constants.
package encoder_out_fifo_pkg;

    localparam int EOF_BUS_SIZE = 32;
    localparam int EOF_DEPTH    = 8;

    // Stored word layout {last, data}; the top and the array keep this bit order for any BUS_SIZE.
    typedef struct packed {
        logic                    last;
        logic [EOF_BUS_SIZE-1:0] data;
    } eof_entry_t;

    localparam logic [31:0] EOF_PTR_RST = '0;

    function automatic int eof_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/encoder_out_fifo_mem.sv
// Simple dual-port storage for the encoder output FIFO: registered write, asynchronous read.
module encoder_out_fifo_mem
    import encoder_out_fifo_pkg::*;
#(
    parameter  int DEPTH = EOF_DEPTH,
    parameter  int WIDTH = EOF_BUS_SIZE + 1,
    localparam int AW    = eof_addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/encoder_out_fifo.sv
// Registered-output FIFO between the encoder and the external do_* bus.
// Define ENCODER_OUT_FIFO_BYPASS_EN to let words skip the array when it is empty (1-edge latency).
module encoder_out_fifo
    import encoder_out_fifo_pkg::*;
#(
    parameter  int BUS_SIZE = EOF_BUS_SIZE,
    parameter  int DEPTH    = EOF_DEPTH,
    localparam int ADDR_W   = eof_addr_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BUS_SIZE-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [BUS_SIZE-1:0] do_data,
    output logic                do_valid,
    output logic                do_last,
    input  logic                do_ready,
    output logic [ADDR_W+1:0]   level,
    output logic [ADDR_W+1:0]   msg_count
);

    localparam logic [ADDR_W:0]   PTR_ONE = 1;
    localparam logic [ADDR_W+1:0] CNT_ONE = 1;

    logic [ADDR_W:0]     r_wr_ptr, r_rd_ptr;
    logic [BUS_SIZE-1:0] r_do_data;
    logic                r_do_last, r_do_valid;
    logic [ADDR_W+1:0]   r_level, r_msg_count;

    logic                w_full, w_empty, w_acc, w_cons, w_out_free, w_load, w_byp, w_we;
    logic [BUS_SIZE:0]   w_rd_entry;

    assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                        (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_acc      = in_valid && !w_full;
    assign w_cons     = r_do_valid && do_ready;
    assign w_out_free = !r_do_valid || do_ready;
    assign w_load     = !w_empty && w_out_free;

`ifdef ENCODER_OUT_FIFO_BYPASS_EN
    // Only when the array is empty, so ordering against stored words is preserved.
    assign w_byp = w_acc && w_empty && w_out_free;
`else
    assign w_byp = 1'b0;
`endif

    assign w_we = w_acc && !w_byp;

    encoder_out_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BUS_SIZE + 1)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata ({in_last, in_data}),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= EOF_PTR_RST[ADDR_W:0];
            r_rd_ptr <= EOF_PTR_RST[ADDR_W:0];
        end else begin
            if (w_we)   r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_load) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_do_data  <= '0;
            r_do_last  <= 1'b0;
            r_do_valid <= 1'b0;
        end else if (w_load) begin
            r_do_data  <= w_rd_entry[BUS_SIZE-1:0];
            r_do_last  <= w_rd_entry[BUS_SIZE];
            r_do_valid <= 1'b1;
        end else if (w_byp) begin
            r_do_data  <= in_data;
            r_do_last  <= in_last;
            r_do_valid <= 1'b1;
        end else if (w_cons) begin
            r_do_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level     <= '0;
            r_msg_count <= '0;
        end else begin
            case ({w_acc, w_cons})
                2'b10:   r_level <= r_level + CNT_ONE;
                2'b01:   r_level <= r_level - CNT_ONE;
                default: r_level <= r_level;
            endcase
            case ({w_acc && in_last, w_cons && r_do_last})
                2'b10:   r_msg_count <= r_msg_count + CNT_ONE;
                2'b01:   r_msg_count <= r_msg_count - CNT_ONE;
                default: r_msg_count <= r_msg_count;
            endcase
        end
    end

    assign in_ready  = !w_full;
    assign do_data   = r_do_data;
    assign do_last   = r_do_last;
    assign do_valid  = r_do_valid;
    assign level     = r_level;
    assign msg_count = r_msg_count;

endmodule

// File: tb/tb_encoder_out_fifo.sv
// Self-checking bench for encoder_out_fifo: vector table, directed corner sequences, random stream vs queue model.
module tb_encoder_out_fifo;

    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 5;
`ifdef ENCODER_OUT_FIFO_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic          clk, rst_n;
    logic [BW-1:0] in_data, do_data;
    logic          in_valid, in_last, in_ready, do_valid, do_last, do_ready;
    logic [LW-1:0] level, msg_count;

    encoder_out_fifo #(.BUS_SIZE(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .do_data(do_data), .do_valid(do_valid), .do_last(do_last), .do_ready(do_ready),
        .level(level), .msg_count(msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: every word held by the FIFO, oldest first, with the edge it was accepted on.
    typedef struct {
        logic          last;
        logic [BW-1:0] data;
        int            t;
    } ment_t;

    ment_t q[$];
    bit    mon_en = 0;
    bit    f_acc, f_cons;
    int    edge_cnt = 0;
    int    n_out = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            int nl;
            nl = 0;
            foreach (q[i]) if (q[i].last) nl++;
            chk("level", level, q.size());
            chk("msg_count", msg_count, nl);
            chk("level_range", level <= DEPTH + 1, 1);
            if (q.size() < DEPTH)           chk("in_ready_room", in_ready, 1);
            else if (q.size() == DEPTH + 1) chk("in_ready_full", in_ready, 0);
            else                            chk("in_ready_edge", in_ready, do_valid);
            if (q.size() == 0)                    chk("do_valid_empty", do_valid, 0);
            else if (edge_cnt - q[0].t >= LAT)    chk("do_valid_head", do_valid, 1);
            if (do_valid && q.size() > 0) begin
                chk("do_data", do_data, q[0].data);
                chk("do_last", do_last, q[0].last);
            end
            f_acc  = in_valid && in_ready;
            f_cons = do_valid && do_ready;
        end
    end

    always @(posedge clk) begin
        if (mon_en) begin
            edge_cnt++;
            if (f_cons && q.size() > 0) begin
                n_out++;
                void'(q.pop_front());
            end
            if (f_acc) q.push_back('{in_last, in_data, edge_cnt});
        end
    end

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          r;
        bit          ev;
        logic [31:0] ed;
        bit          el;
        int          elev;
        int          emsg;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int w, k, got0, sent;
        bit acc, pend;

        in_valid = 0; in_data = '0; in_last = 0; do_ready = 0; rst_n = 0;

        // Reset values while rst_n is held low
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_do_valid", do_valid, 0);
        chk("rst_do_last", do_last, 0);
        chk("rst_do_data", do_data, 0);
        chk("rst_level", level, 0);
        chk("rst_msg", msg_count, 0);
        rst_n = 1;
        @(posedge clk); #1;
        mon_en = 1;

        // Single word, then last-in and last-out on the same edge (row 5)
`ifdef ENCODER_OUT_FIFO_BYPASS_EN
        tbl[0] = '{1, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 1, 1, 1};
        tbl[1] = '{0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 0};
        tbl[2] = '{0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 0};
        tbl[3] = '{1, 32'h11,       1, 0, 1, 32'h11,       1, 1, 1};
`else
        tbl[0] = '{1, 32'hDEADBEEF, 1, 1, 0, 32'h0,        0, 1, 1};
        tbl[1] = '{0, 32'h0,        0, 1, 1, 32'hDEADBEEF, 1, 1, 1};
        tbl[2] = '{0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 0};
        tbl[3] = '{1, 32'h11,       1, 0, 0, 32'h0,        0, 1, 1};
`endif
        tbl[4] = '{1, 32'h22,       1, 0, 1, 32'h11,       1, 2, 2};
        tbl[5] = '{1, 32'h33,       1, 1, 1, 32'h22,       1, 2, 2};
        tbl[6] = '{0, 32'h0,        0, 1, 1, 32'h33,       1, 1, 1};
        tbl[7] = '{0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 0};

        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l; do_ready = tbl[i].r;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", i), do_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), do_data, tbl[i].ed);
                chk($sformatf("tbl%0d_last", i), do_last, tbl[i].el);
            end
            chk($sformatf("tbl%0d_level", i), level, tbl[i].elev);
            chk($sformatf("tbl%0d_msg", i), msg_count, tbl[i].emsg);
        end
        in_valid = 0; in_last = 0;

        // Reset mid-stream: asynchronous clear observed before the next edge
        do_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 32'h100 + i; in_last = (i == 4);
            @(posedge clk); #1;
        end
        in_valid = 0; in_last = 0;
        #1;
        mon_en = 0;
        rst_n  = 0;
        #1;
        chk("mid_rst_do_valid", do_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_msg", msg_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        q.delete();
        @(posedge clk); #1;
        mon_en = 1;

        // Fill with output stalled: 9 words held, the rest wait at the encoder
        w = 0;
        do_ready = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1; in_data = w; in_last = (w % 4 == 3);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) w++;
        end
        chk("fill_accepted", w, 9);
        chk("fill_level", level, 9);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_do_data", do_data, 0);

        // Drain with concurrent fill: contiguous 0x00..0x13
        k = 0;
        do_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1; in_data = w; in_last = (w % 4 == 3);
            @(negedge clk);
            if (do_valid && do_ready) begin
                chk("drain_order", do_data, k);
                k++;
            end
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) w++;
        end
        chk("drain_count", k, 20);
        in_valid = 0; in_last = 0;
        repeat (DEPTH + 4) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", level, 0);

        // Random traffic across several pointer wraps
        got0 = n_out; sent = 0; pend = 0;
        for (int c = 0; c < 2000 && (n_out - got0) < 3 * DEPTH; c++) begin
            if (!pend && sent < 3 * DEPTH && $urandom_range(99) < 70) begin
                pend = 1; in_data = $urandom; in_last = ($urandom_range(3) == 0);
            end
            in_valid = pend;
            do_ready = $urandom_range(1);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                pend = 0; sent++;
            end
        end
        in_valid = 0; in_last = 0;
        chk("rand_sent", sent, 3 * DEPTH);
        chk("rand_out", n_out - got0, 3 * DEPTH);
        chk("rand_msg_end", msg_count, 0);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
